// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_unit_pkg
// Purpose  : Shared widths, FSM state and next-PC select encodings for the fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam int c_pc_w     = 16;
    localparam int c_instr_w  = 9;
    localparam int c_br_off_w = 8;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_SEQ    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JUMP   = 2'd3
    } pc_sel_e;

endpackage : fetch_unit_pkg

`default_nettype wire

// File: rtl/fetch_pc_next.sv
// ============================================================================
// Module   : fetch_pc_next
// Purpose  : Combinational next-PC select: hold, sequential, relative branch, jump.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int PC_W = c_pc_w
) (
    input  pc_sel_e               sel_i,
    input  logic [PC_W-1:0]       pc_i,
    input  logic [PC_W-1:0]       ir_pc_i,
    input  logic [PC_W-1:0]       jump_target_i,
    input  logic [c_br_off_w-1:0] branch_off_i,
    output logic [PC_W-1:0]       pc_next_o
);

    localparam int c_ext_w = PC_W - c_br_off_w;

    logic [PC_W-1:0] w_off_ext;

    // Branches are relative to the instruction being executed, not the fetch PC.
    assign w_off_ext = {{c_ext_w{branch_off_i[c_br_off_w-1]}}, branch_off_i};

    always_comb begin
        pc_next_o = pc_i;
        case (sel_i)
            PC_HOLD:   pc_next_o = pc_i;
            PC_SEQ:    pc_next_o = pc_i + PC_W'(1);
            PC_BRANCH: pc_next_o = ir_pc_i + w_off_ext;
            PC_JUMP:   pc_next_o = jump_target_i;
            default:   pc_next_o = pc_i;
        endcase
    end

endmodule : fetch_pc_next

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch FSM (RESET/RUN/FLUSH/HALT) with PC and IR registers.
//            Optional macro FETCH_HALT_ON_END_EN halts after the word at PROG_LAST.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int PC_W      = c_pc_w,
    parameter int INSTR_W   = c_instr_w,
    parameter int PROG_LAST = 34
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_in,
    input  logic                  branch_en,
    input  logic [c_br_off_w-1:0] branch_off,
    input  logic                  jump_en,
    input  logic [PC_W-1:0]       jump_target,
    input  logic                  halt_in,
    input  logic [INSTR_W-1:0]    instr_in,
    output logic [PC_W-1:0]       pc_out,
    output logic [INSTR_W-1:0]    instr_out,
    output logic [PC_W-1:0]       ir_pc,
    output logic                  instr_valid,
    output logic                  halted
);

`ifdef FETCH_HALT_ON_END_EN
    localparam bit c_halt_on_end = 1'b1;
`else
    localparam bit c_halt_on_end = 1'b0;
`endif

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    ir_pc_q, ir_pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    pc_sel_e            w_pc_sel;
    logic               w_at_last;
    logic               w_end;

    assign w_at_last = valid_q && (ir_pc_q == PC_W'(PROG_LAST));
    assign w_end     = c_halt_on_end && w_at_last;

    fetch_pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .sel_i         (w_pc_sel),
        .pc_i          (pc_q),
        .ir_pc_i       (ir_pc_q),
        .jump_target_i (jump_target),
        .branch_off_i  (branch_off),
        .pc_next_o     (pc_d)
    );

    always_comb begin
        state_d  = state_q;
        w_pc_sel = PC_HOLD;
        ir_d     = ir_q;
        ir_pc_d  = ir_pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN: begin
                if (halt_in || w_end) begin
                    state_d  = S_HALT;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if (jump_en && valid_q) begin
                    w_pc_sel = PC_JUMP;
                    valid_d  = 1'b0;
                    state_d  = S_FLUSH;
                end else if (branch_en && valid_q) begin
                    w_pc_sel = PC_BRANCH;
                    valid_d  = 1'b0;
                    state_d  = S_FLUSH;
                end else if (!stall_in) begin
                    w_pc_sel = PC_SEQ;
                    ir_d     = instr_in;
                    ir_pc_d  = pc_q;
                    valid_d  = 1'b1;
                end
            end
            S_FLUSH: begin
                // The flush cycle is the first fetch from the redirected PC.
                if (halt_in) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    w_pc_sel = PC_SEQ;
                    ir_d     = instr_in;
                    ir_pc_d  = pc_q;
                    valid_d  = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_RESET;
            pc_q     <= '0;
            ir_q     <= '0;
            ir_pc_q  <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            ir_pc_q  <= ir_pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign pc_out      = pc_q;
    assign instr_out   = ir_q;
    assign ir_pc       = ir_pc_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit: directed scenarios plus random
//            redirects/stalls/halts/resets against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int c_pc_w    = 16;
    localparam int c_instr_w = 9;
    localparam int c_last    = 34;
    localparam int c_pc_mod  = 65536;

    logic                 clk;
    logic                 rst_n;
    logic                 stall_in;
    logic                 branch_en;
    logic [7:0]           branch_off;
    logic                 jump_en;
    logic [c_pc_w-1:0]    jump_target;
    logic                 halt_in;
    logic [c_instr_w-1:0] instr_in;
    logic [c_pc_w-1:0]    pc_out;
    logic [c_instr_w-1:0] instr_out;
    logic [c_pc_w-1:0]    ir_pc;
    logic                 instr_valid;
    logic                 halted;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(
        .PC_W      (c_pc_w),
        .INSTR_W   (c_instr_w),
        .PROG_LAST (c_last)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_in    (stall_in),
        .branch_en   (branch_en),
        .branch_off  (branch_off),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .halt_in     (halt_in),
        .instr_in    (instr_in),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .ir_pc       (ir_pc),
        .instr_valid (instr_valid),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction ROM contents: a scrambled function of the address.
    function automatic int rom_word(input int a);
        return ((a * 37 + 11) ^ (a >> 7)) & 'h1FF;
    endfunction

    int rom_tmp;
    always_comb begin
        rom_tmp  = rom_word({16'b0, pc_out});
        instr_in = rom_tmp[c_instr_w-1:0];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the outputs must be after each edge.
    bit m_known   = 0;
    bit m_started = 0;
    bit m_flush   = 0;
    bit m_halted  = 0;
    bit m_valid   = 0;
    int m_pc      = 0;
    int m_irpc    = 0;
    int m_ir      = 0;

    function automatic bit end_hit();
`ifdef FETCH_HALT_ON_END_EN
        return m_valid && (m_irpc == c_last);
`else
        return 1'b0;
`endif
    endfunction

    task automatic m_fetch();
        m_ir    = rom_word(m_pc);
        m_irpc  = m_pc;
        m_pc    = (m_pc + 1) % c_pc_mod;
        m_valid = 1;
    endtask

    always @(posedge clk) begin
        int off;
        off = int'($signed(branch_off));
        if (!rst_n) begin
            m_known = 1; m_started = 0; m_flush = 0; m_halted = 0;
            m_valid = 0; m_pc = 0; m_irpc = 0; m_ir = 0;
        end else if (!m_known || m_halted) begin
        end else if (!m_started) begin
            m_started = 1;
        end else if (halt_in || end_hit()) begin
            m_halted = 1;
            m_valid  = 0;
        end else if (m_flush) begin
            m_flush = 0;
            m_fetch();
        end else if (m_valid && jump_en) begin
            m_pc    = int'(jump_target);
            m_valid = 0;
            m_flush = 1;
        end else if (m_valid && branch_en) begin
            m_pc    = ((m_irpc + off) % c_pc_mod + c_pc_mod) % c_pc_mod;
            m_valid = 0;
            m_flush = 1;
        end else if (!stall_in) begin
            m_fetch();
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("model_pc",     {16'b0, pc_out},        m_pc);
            chk("model_valid",  {31'b0, instr_valid},   {31'b0, m_valid});
            chk("model_halted", {31'b0, halted},        {31'b0, m_halted});
            chk("model_ir_pc",  {16'b0, ir_pc},         m_irpc);
            chk("model_instr",  {23'b0, instr_out},     m_ir);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall_in = 0; branch_en = 0; jump_en = 0; halt_in = 0;
        branch_off = '0; jump_target = '0;
    endtask

    initial begin
        rst_n = 0;
        idle();
        repeat (3) step();
        chk("reset_pc",     {16'b0, pc_out},      32'd0);
        chk("reset_valid",  {31'b0, instr_valid}, 32'd0);
        chk("reset_halted", {31'b0, halted},      32'd0);
        chk("reset_ir",     {23'b0, instr_out},   32'd0);
        chk("reset_ir_pc",  {16'b0, ir_pc},       32'd0);

        // Release: first RUN cycle, then address 0 becomes valid.
        rst_n = 1;
        step();
        chk("rel1_valid", {31'b0, instr_valid}, 32'd0);
        chk("rel1_pc",    {16'b0, pc_out},      32'd0);
        step();
        chk("rel2_valid", {31'b0, instr_valid}, 32'd1);
        chk("rel2_ir_pc", {16'b0, ir_pc},       32'd0);
        chk("rel2_pc",    {16'b0, pc_out},      32'd1);
        chk("rel2_instr", {23'b0, instr_out},   32'd11);
        for (int i = 1; i <= 20; i++) begin
            step();
            chk("seq_pc", {16'b0, pc_out}, i + 1);
        end
        chk("seq_ir_pc", {16'b0, ir_pc}, 32'd20);

        // Backward branch from ir_pc 20 by -4.
        branch_en = 1; branch_off = 8'hFC;
        step();
        idle();
        chk("br_pc",    {16'b0, pc_out},      32'd16);
        chk("br_valid", {31'b0, instr_valid}, 32'd0);
        step();
        chk("br_ir_pc", {16'b0, ir_pc},       32'd16);
        chk("br_v2",    {31'b0, instr_valid}, 32'd1);
        chk("br_pc2",   {16'b0, pc_out},      32'd17);

        // Jump beats branch.
        jump_en = 1; branch_en = 1; jump_target = 16'd5; branch_off = 8'h10;
        step();
        idle();
        chk("jb_pc",    {16'b0, pc_out},      32'd5);
        chk("jb_valid", {31'b0, instr_valid}, 32'd0);
        step();
        chk("jb_ir_pc", {16'b0, ir_pc},       32'd5);

        // Stall three cycles at PC 7.
        step();
        chk("st_pc0", {16'b0, pc_out}, 32'd7);
        stall_in = 1;
        repeat (3) begin
            step();
            chk("st_pc",    {16'b0, pc_out},      32'd7);
            chk("st_ir_pc", {16'b0, ir_pc},       32'd6);
            chk("st_valid", {31'b0, instr_valid}, 32'd1);
        end
        idle();
        step();
        chk("st_resume", {16'b0, ir_pc}, 32'd7);

        // Jump to top of address space wraps.
        jump_en = 1; jump_target = 16'hFFFF;
        step();
        idle();
        step();
        chk("wrap_pc",    {16'b0, pc_out}, 32'd0);
        chk("wrap_ir_pc", {16'b0, ir_pc},  32'h0000FFFF);

        // Branch below zero, presented together with stall.
        step();
        stall_in = 1; branch_en = 1; branch_off = 8'hFC;
        step();
        idle();
        chk("neg_pc", {16'b0, pc_out}, 32'h0000FFFC);
        step();

        // Halt: frozen, ignores redirects, only reset exits.
        rst_n = 0; step(); rst_n = 1;
        repeat (3) step();
        halt_in = 1; jump_en = 1; jump_target = 16'd99;
        step();
        chk("halt_h",  {31'b0, halted},      32'd1);
        chk("halt_v",  {31'b0, instr_valid}, 32'd0);
        chk("halt_pc", {16'b0, pc_out},      32'd2);
        halt_in = 0;
        repeat (2) step();
        chk("halt_hold", {16'b0, pc_out}, 32'd2);
        rst_n = 0; halt_in = 1; stall_in = 1;
        step();
        chk("halt_rst_pc", {16'b0, pc_out}, 32'd0);
        chk("halt_rst_h",  {31'b0, halted}, 32'd0);
        idle();
        rst_n = 1;

        // Random traffic, checked every cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            rst_n       = ($urandom_range(59) != 0);
            halt_in     = ($urandom_range(149) == 0);
            jump_en     = ($urandom_range(15) == 0);
            branch_en   = ($urandom_range(7) == 0);
            stall_in    = ($urandom_range(3) == 0);
            branch_off  = 8'($urandom);
            jump_target = ($urandom_range(3) == 0) ? 16'(16'hFFFF - $urandom_range(3))
                                                   : 16'($urandom);
            step();
        end
        idle();

`ifdef FETCH_HALT_ON_END_EN
        rst_n = 0; step(); rst_n = 1;
        begin
            bit seen;
            seen = 0;
            for (int k = 0; k < 60 && !seen; k++) begin
                step();
                seen = instr_valid && (ir_pc == 16'(c_last));
            end
            chk("end_reached", {31'b0, seen}, 32'd1);
        end
        step();
        chk("end_halted", {31'b0, halted},      32'd1);
        chk("end_valid",  {31'b0, instr_valid}, 32'd0);
        rst_n = 0; step(); rst_n = 1;
        step(); step();
        chk("end_restart", {16'b0, ir_pc}, 32'd0);
`endif

        rst_n = 0; step(); step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit

`default_nettype wire
